// File: rtl/led_pkg.sv
// Shared definitions for the LED panel scan controller: FSM state encoding,
// default geometry/timing constants and a width helper.
package led_pkg;

  localparam int DEF_COLS      = 32;
  localparam int DEF_ROWS      = 2;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_ON_CYCLES = 256;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    ADDR,
    DISPLAY
  } led_state_e;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_fb_ram.sv
// Single-bit framebuffer: one write port, one synchronous read port.
// A same-address read and write in one cycle returns the previous contents.
module led_fb_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Row-scanning driver for a 1-bit LED matrix panel (shift, blank, latch,
// address, display). Optional LED_BRIGHTNESS_EN adds a 4-bit brightness input.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int ON_CYCLES = DEF_ON_CYCLES
) (
  input  logic                                clkin,
  input  logic                                rstin,
  input  logic                                en,
  input  logic                                wr_en,
  input  logic [clog2_min1(COLS*ROWS)-1:0]    wr_addr,
  input  logic                                wr_data,
`ifdef LED_BRIGHTNESS_EN
  input  logic [3:0]                          bright,
`endif
  output logic                                R1,
  output logic [clog2_min1(ROWS)-1:0]         A,
  output logic                                clk,
  output logic                                lat,
  output logic                                S,
  output logic                                frame_done
);

  localparam int AW      = clog2_min1(COLS*ROWS);
  localparam int RW      = clog2_min1(ROWS);
  localparam int CW      = clog2_min1(COLS);
  localparam int CNT_MAX = (ON_CYCLES > 2*CLK_DIV) ? ON_CYCLES : 2*CLK_DIV;
  localparam int CNTW    = clog2_min1(CNT_MAX + 1);
  localparam int SH_LAST = 2*CLK_DIV - 1;
  localparam int ON_LAST = ON_CYCLES - 1;

  led_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q, row_nxt;
  logic [AW-1:0]   rd_addr, row_base, nrow_base;
  logic            rd_data;
  logic            wrap_pend_q;
  logic            sh_last, col_last, row_last, disp_end, enter_shift, load_px;
  logic            disp_on;

  led_fb_ram #(
    .DEPTH (COLS*ROWS),
    .AW    (AW)
  ) u_fb (
    .clk   (clkin),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign sh_last     = (state_q == SHIFT) && (cnt_q == CNTW'(SH_LAST));
  assign col_last    = (col_q == CW'(COLS-1));
  assign row_last    = (row_q == RW'(ROWS-1));
  assign disp_end    = (state_q == DISPLAY) && (cnt_q == CNTW'(ON_LAST));
  assign enter_shift = (state_d == SHIFT) && (state_q != SHIFT);
  assign load_px     = enter_shift || (sh_last && !col_last);
  assign row_nxt     = row_last ? '0 : row_q + 1'b1;
  assign row_base    = AW'(int'(row_q) * COLS);
  assign nrow_base   = AW'(int'(row_nxt) * COLS);

  // The pixel for the next column window is read throughout the current one,
  // so R1 can be loaded at the window boundary with no visible read latency.
  always_comb begin
    rd_addr = nrow_base;
    if (rstin) begin
      rd_addr = '0;
    end else if (state_q == IDLE) begin
      rd_addr = row_base;
    end else if (state_q == SHIFT && !col_last) begin
      rd_addr = row_base + AW'(col_q) + AW'(1);
    end
  end

`ifdef LED_BRIGHTNESS_EN
  logic [CNTW-1:0] on_len_q;

  always_ff @(posedge clkin) begin
    if (rstin) begin
      on_len_q <= '0;
    end else if (state_q == ADDR) begin
      on_len_q <= CNTW'(((int'(bright) + 1) * ON_CYCLES) / 16);
    end
  end

  assign disp_on = (cnt_q < on_len_q);
`else
  assign disp_on = 1'b1;
`endif

  always_ff @(posedge clkin) begin
    if (rstin) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clk     = 1'b0;
    lat     = 1'b0;
    S       = 1'b1;
    unique case (state_q)
      IDLE:    if (en) state_d = SHIFT;
      SHIFT: begin
        clk = (cnt_q >= CNTW'(CLK_DIV));
        if (sh_last && col_last) state_d = BLANK;
      end
      BLANK:   if (cnt_q == CNTW'(1)) state_d = LATCH;
      LATCH: begin
        lat = 1'b1;
        if (cnt_q == CNTW'(1)) state_d = ADDR;
      end
      ADDR:    state_d = DISPLAY;
      DISPLAY: begin
        S = !disp_on;
        if (disp_end) state_d = en ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A wrap that ends in IDLE is remembered so the pulse still marks the
  // first SHIFT of the following frame.
  always_ff @(posedge clkin) begin
    if (rstin) begin
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      A           <= '0;
      R1          <= 1'b0;
      frame_done  <= 1'b0;
      wrap_pend_q <= 1'b0;
    end else begin
      if (state_d != state_q || sh_last) begin
        cnt_q <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (enter_shift) begin
        col_q <= '0;
      end else if (sh_last && !col_last) begin
        col_q <= col_q + 1'b1;
      end

      if (load_px) begin
        R1 <= rd_data;
      end

      if (state_q == LATCH && state_d == ADDR) begin
        A <= row_q;
      end

      if (disp_end) begin
        row_q <= row_nxt;
      end

      frame_done <= enter_shift && (wrap_pend_q || (disp_end && row_last));

      if (enter_shift) begin
        wrap_pend_q <= 1'b0;
      end else if (disp_end && row_last) begin
        wrap_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed self-checking bench for led_scan_ctrl at default geometry.
// Define LED_BRIGHTNESS_EN to also exercise the brightness input.
`timescale 1ns/1ps
module tb_led_scan_ctrl;

  localparam int COLS      = 32;
  localparam int ROWS      = 2;
  localparam int CLK_DIV   = 4;
  localparam int ON_CYCLES = 256;
  localparam int SHIFT_LEN = 256;   // 2*4*32
  localparam int ROW_LEN   = 517;   // 256 + 5 + 256
  localparam int DISP_T0   = 261;   // first DISPLAY cycle in a row

  logic       clkin = 1'b0;
  logic       rstin = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic       wr_data = 1'b0;
  logic       R1;
  logic [0:0] A;
  logic       clk, lat, S, frame_done;
`ifdef LED_BRIGHTNESS_EN
  logic [3:0] bright = 4'd15;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic fb_model [64];

  always #5 clkin = ~clkin;

  led_scan_ctrl #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .CLK_DIV   (CLK_DIV),
    .ON_CYCLES (ON_CYCLES)
  ) dut (
    .clkin      (clkin),
    .rstin      (rstin),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef LED_BRIGHTNESS_EN
    .bright     (bright),
`endif
    .R1         (R1),
    .A          (A),
    .clk        (clk),
    .lat        (lat),
    .S          (S),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(negedge clkin);
  endtask

  // Walks one row cycle by cycle from its first SHIFT cycle, checking the
  // panel signals against the hand-derived schedule. Optional en drop and
  // framebuffer write at given cycle offsets.
  task automatic scan_row(input int row, input bit fd, input int ncyc,
                          input int drop_at, input int w_at,
                          input int w_addr, input bit w_val);
    logic [3:0] exp_v, got_v;
    int on_len;
`ifdef LED_BRIGHTNESS_EN
    on_len = ((int'(bright) + 1) * ON_CYCLES) / 16;
`else
    on_len = ON_CYCLES;
`endif
    for (int t = 0; t < ncyc; t++) begin
      // {clk, lat, S, frame_done}
      if (t < SHIFT_LEN)              exp_v = {((t % 8) >= CLK_DIV), 1'b0, 1'b1, (fd && t == 0)};
      else if (t < SHIFT_LEN + 2)     exp_v = 4'b0010;
      else if (t < SHIFT_LEN + 4)     exp_v = 4'b0110;
      else if (t < DISP_T0)           exp_v = 4'b0010;
      else                            exp_v = {2'b00, !((t - DISP_T0) < on_len), 1'b0};
      got_v = {clk, lat, S, frame_done};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL ctrl row%0d t=%0d got {clk,lat,S,fd}=%b exp=%b", row, t, got_v, exp_v);
      end
      if (t < SHIFT_LEN) begin
        n_cmp++;
        if (R1 !== fb_model[row*COLS + t/8]) begin
          n_fail++;
          $display("FAIL R1 row%0d col%0d t=%0d got=%b exp=%b", row, t/8, t, R1, fb_model[row*COLS + t/8]);
        end
      end
      if (t >= DISP_T0) begin
        n_cmp++;
        if (A !== row[0:0]) begin
          n_fail++;
          $display("FAIL A row%0d t=%0d got=%0d exp=%0d", row, t, A, row);
        end
      end
      if (t == drop_at) en = 1'b0;
      if (t == w_at) begin
        wr_en = 1'b1; wr_addr = w_addr[5:0]; wr_data = w_val;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic check_idle(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      n_cmp++;
      if ({clk, lat, S, frame_done} !== 4'b0010) begin
        n_fail++;
        $display("FAIL idle i=%0d got {clk,lat,S,fd}=%b exp=0010", i, {clk, lat, S, frame_done});
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rstin = 1'b1; en = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({clk, lat, S, frame_done, R1, A} !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset got {clk,lat,S,fd,R1,A}=%b exp=001000", {clk, lat, S, frame_done, R1, A});
    end
    rstin = 1'b0;
    tick();
  endtask

  task automatic test_checkerboard();
    for (int a = 0; a < 64; a++) begin
      fb_model[a] = (a % 2 == 0);
      wr_en = 1'b1; wr_addr = 6'(a); wr_data = fb_model[a];
      tick();
    end
    wr_en = 1'b0;
    check_idle(3);
    en = 1'b1;
    tick();
    scan_row(0, 1'b0, ROW_LEN, -1, -1, 0, 1'b0);
    scan_row(1, 1'b0, ROW_LEN, -1, -1, 0, 1'b0);
  endtask

  task automatic test_frame_done();
    // Row 0 start here is 1034 cycles after the first SHIFT entry.
    scan_row(0, 1'b1, ROW_LEN, -1, -1, 0, 1'b0);
  endtask

  task automatic test_en_drop();
    scan_row(1, 1'b0, ROW_LEN, 100, -1, 0, 1'b0);
    check_idle(10);
    en = 1'b1;
    tick();
    scan_row(0, 1'b1, ROW_LEN, -1, -1, 0, 1'b0);
  endtask

  task automatic test_reset_latch();
    scan_row(1, 1'b0, 258, -1, -1, 0, 1'b0);
    n_cmp++;
    if (lat !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_before_reset got=%b exp=1", lat);
    end
    rstin = 1'b1;
    tick();
    n_cmp++;
    if ({clk, lat, S, frame_done, R1, A} !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset_in_latch got {clk,lat,S,fd,R1,A}=%b exp=001000", {clk, lat, S, frame_done, R1, A});
    end
    rstin = 1'b0;
    tick();
    scan_row(0, 1'b0, ROW_LEN, -1, -1, 0, 1'b0);
  endtask

  task automatic test_write_collision();
    scan_row(1, 1'b0, ROW_LEN, -1, 300, 6, 1'b0);
    fb_model[6] = 1'b0;
    scan_row(0, 1'b1, ROW_LEN, -1, 42, 5, 1'b1);
    fb_model[5] = 1'b1;
    scan_row(1, 1'b0, ROW_LEN, -1, -1, 0, 1'b0);
    scan_row(0, 1'b1, ROW_LEN, -1, -1, 0, 1'b0);
  endtask

`ifdef LED_BRIGHTNESS_EN
  task automatic test_brightness();
    bright = 4'd0;
    scan_row(1, 1'b0, ROW_LEN, -1, -1, 0, 1'b0);
    bright = 4'd15;
    scan_row(0, 1'b1, ROW_LEN, -1, -1, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_checkerboard();
    test_frame_done();
    test_en_drop();
    test_reset_latch();
    test_write_collision();
`ifdef LED_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 32: pixels shifted per row.
REQ-002 SHALL have parameter ROWS, default 2: scanned rows, A width = clog2(ROWS) (min 1).
REQ-003 SHALL have parameter CLK_DIV, default 4: clkin cycles per panel-clock half period.
REQ-004 SHALL have parameter ON_CYCLES, default 256: clkin cycles per DISPLAY phase.
REQ-005 SHALL have port clkin  input  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rstin  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  scan enable.
REQ-008 SHALL have port wr_en  input  1  framebuffer write strobe.
REQ-009 SHALL have port wr_addr  input  clog2(COLS*ROWS)  pixel address, row*COLS+col.
REQ-010 SHALL have port wr_data  input  1  pixel value.
REQ-011 SHALL have port R1  output  1  panel serial data.
REQ-012 SHALL have port A  output  clog2(ROWS)  panel row address.
REQ-013 SHALL have port clk  output  1  panel shift clock.
REQ-014 SHALL have port lat  output  1  panel latch.
REQ-015 SHALL have port S  output  1  panel output-disable, 1 = LEDs off.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at end of last row.

Function
REQ-017 SHALL use FSM states IDLE, SHIFT, BLANK, LATCH, ADDR, DISPLAY.
REQ-018 IDLE: S=1, clk=0, lat=0; leave for SHIFT of row 0 on the cycle after en=1 is sampled.
REQ-019 SHIFT: per column, drive R1 = fb[row*COLS+col]; hold clk=0 for CLK_DIV cycles, then clk=1 for CLK_DIV cycles; keep R1 stable across the whole 2*CLK_DIV window.
REQ-020 After column COLS-1 completes its high phase, SHALL enter BLANK with clk=0.
REQ-021 BLANK: S=1 for 2 cycles. LATCH: lat=1 for 2 cycles. ADDR: A <= row for 1 cycle.
REQ-022 DISPLAY: S=0 for ON_CYCLES cycles, then S=1; advance row.
REQ-023 S SHALL be 1 in every state except DISPLAY.
REQ-024 Row period SHALL be exactly 2*CLK_DIV*COLS+5+ON_CYCLES cycles (517 at defaults).
REQ-025 Row ROWS-1 -> 0 wrap SHALL pulse frame_done for the first cycle of the next SHIFT.
REQ-026 en=0 SHALL take effect only at DISPLAY end: go to IDLE and leave the row state intact; an active row is never truncated.
REQ-027 Writes SHALL be accepted every cycle in any state. A write and a read to the same address in the same cycle SHALL return the old value to R1.
REQ-028 The framebuffer read latency (1 cycle) SHALL be hidden: R1 is valid from the first cycle of each column window.

Reset
REQ-029 While rstin=1 at a clkin edge: state=IDLE, row=0, col=0, R1=0, A=0, clk=0, lat=0, S=1, frame_done=0.
REQ-030 Reset mid-operation SHALL abort immediately to REQ-029 values; framebuffer contents SHALL be preserved.

Configuration
REQ-031 Macro LED_BRIGHTNESS_EN defined: add input bright[3:0], sampled at DISPLAY entry. S=0 for the first (bright+1)*ON_CYCLES/16 DISPLAY cycles, then S=1 for the rest. DISPLAY length is unchanged.
REQ-032 LED_BRIGHTNESS_EN undefined: port bright is absent and S=0 for all ON_CYCLES.

Structure
REQ-033 Package led_pkg SHALL hold the state enum and the default COLS/ROWS/CLK_DIV/ON_CYCLES constants.
REQ-034 Sub-module led_fb_ram SHALL implement the framebuffer: 1R1W, synchronous read, COLS*ROWS x 1 bit.

Verification
REQ-035 Write checkerboard (addr even=1); en=1 -> row 0 R1 sequence 1,0,1,0... sampled on clk rising edges, 32 edges, then lat high 2 cycles, A=0, S low 256 cycles.
REQ-036 Run 2 rows -> frame_done pulses once, 1034 cycles after the first SHIFT entry; A sequence 0,1,0.
REQ-037 Drop en mid-SHIFT of row 1 -> row 1 completes its DISPLAY, then IDLE with S=1; re-assert en -> row 0 resumes.
REQ-038 Assert rstin during LATCH -> next cycle lat=0, S=1, A=0, state IDLE; rescan shows pre-reset pixel data.
REQ-039 Write addr 5 during SHIFT of column 5, same cycle -> old value shifted; next frame shows new value.
REQ-040 With LED_BRIGHTNESS_EN: bright=0 -> S low for 16 cycles; bright=15 -> 256; row period 517 in both cases.
